// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port, decode valid/ready
// port and the redirect/halt side-band between fetch, execute and decode.
interface fetch_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
);
  logic                 imem_req;
  logic [ADDR_SIZE-1:0] imem_addr;
  logic [WORD_SIZE-1:0] imem_rdata;
  logic                 imem_ack;
  logic [WORD_SIZE-1:0] instr_out;
  logic [ADDR_SIZE-1:0] pc_out;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 redirect;
  logic [ADDR_SIZE-1:0] redirect_pc;
  logic                 halted;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, instr_out, pc_out, instr_valid, halted,
    input  imem_rdata, imem_ack, instr_ready, redirect, redirect_pc
  );

  // memory / decode / execute side
  modport slave (
    input  imem_req, imem_addr, instr_out, pc_out, instr_valid, halted,
    output imem_rdata, imem_ack, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time,
// holds the fetched word for decode, squashes wrong-path words on redirect
// and parks in HALT once a HALT opcode is consumed.
module fetch_unit #(
  parameter int                     WORD_SIZE   = 16,
  parameter int                     ADDR_SIZE   = 8,
  parameter int                     OPCODE_SIZE = 4,
  parameter logic [ADDR_SIZE-1:0]   RESET_PC    = '0,
  parameter logic [OPCODE_SIZE-1:0] HALT_OPCODE = '1
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  f
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALT} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [ADDR_SIZE-1:0] req_addr_q, req_addr_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [ADDR_SIZE-1:0] pc_out_q, pc_out_d;
  logic                 valid_q, valid_d;
  // set when a redirect lands while a request is outstanding: the word that
  // eventually comes back belongs to the old path and must be dropped
  logic                 discard_q, discard_d;

  logic [OPCODE_SIZE-1:0] opcode;
  assign opcode = instr_q[WORD_SIZE-1 -: OPCODE_SIZE];

  // state and datapath registers, all reset asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      discard_q  <= discard_d;
    end
  end

  // next-state and datapath updates; redirect always wins over handshakes
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    discard_d  = discard_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (f.redirect) begin
          pc_d       = f.redirect_pc;
          req_addr_d = f.redirect_pc;
        end
      end
      S_REQ: begin
        if (f.imem_ack) begin
          if (discard_q || f.redirect) begin
            // stale word: drop it and reissue at the newest target
            pc_d       = f.redirect ? f.redirect_pc : pc_q;
            req_addr_d = f.redirect ? f.redirect_pc : pc_q;
            discard_d  = 1'b0;
          end else begin
            instr_d  = f.imem_rdata;
            pc_out_d = req_addr_q;
            valid_d  = 1'b1;
            pc_d     = req_addr_q + ADDR_SIZE'(1);
            state_d  = S_HOLD;
          end
        end else if (f.redirect) begin
          // outstanding request must still complete at its original address
          pc_d      = f.redirect_pc;
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (f.redirect) begin
          valid_d    = 1'b0;
          pc_d       = f.redirect_pc;
          req_addr_d = f.redirect_pc;
          state_d    = S_REQ;
        end else if (f.instr_ready) begin
          valid_d = 1'b0;
          if (opcode == HALT_OPCODE) begin
            state_d = S_HALT;
          end else begin
            req_addr_d = pc_q;
            state_d    = S_REQ;
          end
        end
      end
      S_HALT: begin
        if (f.redirect) begin
          pc_d       = f.redirect_pc;
          req_addr_d = f.redirect_pc;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign f.imem_req    = (state_q == S_REQ);
  assign f.imem_addr   = req_addr_q;
  assign f.instr_out   = instr_q;
  assign f.pc_out      = pc_out_q;
  assign f.instr_valid = valid_q;
  assign f.halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run
// checked against a program-order model (next expected fetch address).
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if f();
  fetch_unit dut (.clk(clk), .rst_n(rst_n), .f(f));

  logic [15:0] mem [256];
  int          ws_cfg = 0;   // wait states per request, -1 = random 0..3
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory responder: counts down wait states, acks with mem[addr]
  int         wcnt = 0;
  bit         busy = 0;
  bit         prev_ack = 0;
  logic [7:0] cur_addr = '0;
  always @(negedge clk) begin
    if (f.imem_req === 1'b1) begin
      if (!busy || prev_ack) begin
        busy     = 1;
        cur_addr = f.imem_addr;
        wcnt     = (ws_cfg < 0) ? int'($urandom_range(0, 3)) : ws_cfg;
      end else begin
        chk("addr_stable", f.imem_addr, cur_addr);
      end
      if (wcnt == 0) begin
        f.imem_ack   = 1'b1;
        f.imem_rdata = mem[f.imem_addr];
      end else begin
        f.imem_ack = 1'b0;
        wcnt--;
      end
    end else begin
      busy       = 0;
      f.imem_ack = 1'b0;
    end
    prev_ack = f.imem_ack;
  end

  task automatic wait_valid(input string tag);
    int k = 0;
    while (f.instr_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_wait_valid"}, f.instr_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] hold_instr;
    logic [7:0]  hold_pc;
    logic [7:0]  exp_pc;
    int          n;
    int          first_new;
    int          acc;
    bit          red;

    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'hE;
      mem[i] = w;
    end
    f.instr_ready = 1'b0;
    f.redirect    = 1'b0;
    f.redirect_pc = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req", f.imem_req, 0);
    chk("rst_valid", f.instr_valid, 0);
    chk("rst_halted", f.halted, 0);
    chk("rst_instr", f.instr_out, 0);
    chk("rst_pc_out", f.pc_out, 0);

    // zero-wait fetch of 0x1234 at address 0
    mem[0] = 16'h1234;
    ws_cfg = 0;
    f.instr_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("zw_req", f.imem_req, 1);
    chk("zw_addr", f.imem_addr, 0);
    @(negedge clk);
    chk("zw_valid", f.instr_valid, 1);
    chk("zw_instr", f.instr_out, 16'h1234);
    chk("zw_pc_out", f.pc_out, 0);
    chk("zw_req_low", f.imem_req, 0);
    @(negedge clk);
    chk("zw_next_req", f.imem_req, 1);
    chk("zw_next_addr", f.imem_addr, 1);

    // two wait states at address 5: request visible for 3 cycles
    rst_n = 1'b0;
    f.instr_ready = 1'b0;
    ws_cfg = 2;
    @(negedge clk);
    rst_n = 1'b1;
    f.redirect = 1'b1;
    f.redirect_pc = 8'h05;
    @(negedge clk);
    f.redirect = 1'b0;
    n = 0;
    while (f.imem_req === 1'b1 && n < 10) begin
      chk("ws_addr", f.imem_addr, 5);
      n++;
      @(negedge clk);
    end
    chk("ws_req_cycles", n, 3);
    chk("ws_valid", f.instr_valid, 1);
    chk("ws_pc_out", f.pc_out, 5);
    chk("ws_instr", f.instr_out, mem[5]);

    // decode stalls 4 cycles: held outputs stable, no new request
    hold_instr = f.instr_out;
    hold_pc = f.pc_out;
    repeat (4) begin
      @(negedge clk);
      chk("hold_valid", f.instr_valid, 1);
      chk("hold_instr", f.instr_out, hold_instr);
      chk("hold_pc", f.pc_out, hold_pc);
      chk("hold_req", f.imem_req, 0);
    end
    f.instr_ready = 1'b1;
    @(negedge clk);
    chk("ws_next_addr", f.imem_addr, 6);
    f.instr_ready = 1'b0;

    // redirect to 0x40 while request to 0x03 outstanding: 0xBEEF dropped
    rst_n = 1'b0;
    ws_cfg = 2;
    mem[3] = 16'hBEEF;
    mem[8'h40] = 16'h0040;
    @(negedge clk);
    rst_n = 1'b1;
    f.redirect = 1'b1;
    f.redirect_pc = 8'h03;
    @(negedge clk);
    chk("rd_old_addr", f.imem_addr, 3);
    f.redirect_pc = 8'h40;
    @(negedge clk);
    f.redirect = 1'b0;
    first_new = -1;
    n = 0;
    while (f.instr_valid !== 1'b1 && n < 20) begin
      if (f.imem_req === 1'b1 && f.imem_addr != 8'h03 && first_new < 0)
        first_new = int'(f.imem_addr);
      @(negedge clk);
      n++;
    end
    chk("rd_next_addr", first_new, 8'h40);
    chk("rd_valid", f.instr_valid, 1);
    chk("rd_pc_out", f.pc_out, 8'h40);
    chk("rd_instr", f.instr_out, 16'h0040);

    // HALT opcode at 0x41, then redirect to 0x10 resumes
    mem[8'h41] = 16'hF000;
    f.instr_ready = 1'b1;
    @(negedge clk);
    wait_valid("halt");
    chk("halt_pc_out", f.pc_out, 8'h41);
    chk("halt_instr", f.instr_out, 16'hF000);
    @(negedge clk);
    chk("halt_halted", f.halted, 1);
    chk("halt_valid", f.instr_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("halt_req_low", f.imem_req, 0);
      chk("halt_stays", f.halted, 1);
    end
    f.instr_ready = 1'b0;
    f.redirect = 1'b1;
    f.redirect_pc = 8'h10;
    @(negedge clk);
    f.redirect = 1'b0;
    chk("resume_halted", f.halted, 0);
    chk("resume_req", f.imem_req, 1);
    chk("resume_addr", f.imem_addr, 8'h10);
    wait_valid("resume");
    chk("resume_pc_out", f.pc_out, 8'h10);
    chk("resume_instr", f.instr_out, mem[8'h10]);

    // redirect out of HOLD to 0xFF, then PC wraps to 0x00
    f.redirect = 1'b1;
    f.redirect_pc = 8'hFF;
    @(negedge clk);
    f.redirect = 1'b0;
    chk("wrap_squash", f.instr_valid, 0);
    chk("wrap_addr_ff", f.imem_addr, 8'hFF);
    wait_valid("wrap");
    chk("wrap_pc_out", f.pc_out, 8'hFF);
    f.instr_ready = 1'b1;
    @(negedge clk);
    chk("wrap_req", f.imem_req, 1);
    chk("wrap_addr_00", f.imem_addr, 8'h00);
    f.instr_ready = 1'b0;

    // asynchronous reset in the middle of a request
    ws_cfg = 3;
    @(negedge clk);
    chk("mr_req_before", f.imem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_req", f.imem_req, 0);
    chk("mr_valid", f.instr_valid, 0);
    chk("mr_halted", f.halted, 0);
    chk("mr_pc_out", f.pc_out, 0);
    @(negedge clk);

    // randomized run against a program-order model
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h1;
      mem[i] = w;
    end
    ws_cfg = -1;
    exp_pc = 8'h00;
    acc = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_excl", 32'(f.instr_valid & f.imem_req), 0);
      red = ($urandom_range(0, 9) == 0);
      f.redirect = red;
      if (red) f.redirect_pc = 8'($urandom);
      f.instr_ready = 1'($urandom_range(0, 1));
      if (red) begin
        exp_pc = f.redirect_pc;
      end else if (f.instr_valid === 1'b1 && f.instr_ready) begin
        chk("rnd_pc_out", f.pc_out, exp_pc);
        chk("rnd_instr", f.instr_out, mem[exp_pc]);
        exp_pc = exp_pc + 8'd1;
        acc++;
      end
    end
    f.redirect = 1'b0;
    f.instr_ready = 1'b0;
    chk("rnd_progress", 32'(acc > 100), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
